sync_gp_fifo: RTL and testbench

// Single-clock general-purpose FIFO: same-domain buffering on both sides of the CDC FIFOs.

---
 rtl/sync_gp_fifo.sv | 125 ++++++++++++
 tb/tb_sync_gp_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_gp_fifo.sv
// rtl/sync_gp_fifo.sv - single-clock FIFO for any depth >= 2 with occupancy, threshold flags and sticky errors
module sync_gp_fifo #(
    parameter int SLOTS     = 4,
    parameter int WIDTH     = 8,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 1
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         clear_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    output logic                         wr_full_o,
    output logic                         wr_afull_o,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         rd_empty_o,
    output logic                         rd_aempty_o,
    output logic [$clog2(SLOTS+1)-1:0]   count_o,
    output logic                         ovf_o,
    output logic                         udf_o
);

    localparam int PW = $clog2(SLOTS);
    localparam int CW = $clog2(SLOTS + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(SLOTS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SLOTS);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

    if (SLOTS < 2) begin : g_chk_slots
        $error("sync_gp_fifo: SLOTS must be >= 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > SLOTS) begin : g_chk_afull
        $error("sync_gp_fifo: AFULL_TH must be within 1..SLOTS");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH >= SLOTS) begin : g_chk_aempty
        $error("sync_gp_fifo: AEMPTY_TH must be within 0..SLOTS-1");
    end

    logic [WIDTH-1:0] r_mem [SLOTS];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en_i && !w_full;
    assign w_rd_acc = rd_en_i && !w_empty;

    assign wr_full_o   = w_full;
    assign rd_empty_o  = w_empty;
    assign wr_afull_o  = (r_count >= AF_CNT);
    assign rd_aempty_o = (r_count <= AE_CNT);
    assign count_o     = r_count;
    assign ovf_o       = r_ovf;
    assign udf_o       = r_udf;

    // Explicit wrap keeps non-power-of-2 depths from aliasing onto unused slots.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en_i && w_full) begin
                r_ovf <= 1'b1;
            end
            if (rd_en_i && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n && !clear_i && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data_o = r_mem[r_rd_ptr];
    end else begin : g_reg_rd
        logic [WIDTH-1:0] r_rd_data;

        // Output register is left alone by clear so the last delivered word stays visible.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                r_rd_data <= '0;
            end else if (!clear_i && w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end
        end

        assign rd_data_o = r_rd_data;
    end

endmodule

// File: tb/tb_sync_gp_fifo.sv
// tb/tb_sync_gp_fifo.sv - queue-model bench for sync_gp_fifo (SLOTS=5 FWFT=1 and SLOTS=4 FWFT=0)
module tb_sync_gp_fifo;

    logic       clk    = 1'b0;
    logic       arst_n = 1'b0;
    logic       clear  = 1'b0;
    logic       wr     = 1'b0;
    logic       rd     = 1'b0;
    logic [7:0] wd     = 8'h00;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_f
        localparam int SL = (g == 0) ? 5 : 4;
        localparam int FW = (g == 0) ? 1 : 0;

        logic                      full, afull, empty, aempty, ovf, udf;
        logic [7:0]                rdata;
        logic [$clog2(SL+1)-1:0]   cnt;

        sync_gp_fifo #(.SLOTS(SL), .WIDTH(8), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(FW)) u_dut (
            .clk(clk), .arst_n(arst_n), .clear_i(clear),
            .wr_en_i(wr), .wr_data_i(wd), .wr_full_o(full), .wr_afull_o(afull),
            .rd_en_i(rd), .rd_data_o(rdata), .rd_empty_o(empty), .rd_aempty_o(aempty),
            .count_o(cnt), .ovf_o(ovf), .udf_o(udf)
        );

        logic [7:0] mq [$];
        bit         m_ovf = 1'b0;
        bit         m_udf = 1'b0;
        logic [7:0] m_rd  = 8'h00;
        bit         m_f, m_e;

        // Reference: contents as a queue, rules applied once per clock edge.
        initial forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) begin
                mq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rd = 8'h00;
            end else if (clear) begin
                mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                m_f = (mq.size() == SL);
                m_e = (mq.size() == 0);
                if (wr && m_f) m_ovf = 1'b1;
                if (rd && m_e) m_udf = 1'b1;
                if (rd && !m_e) m_rd = mq.pop_front();
                if (wr && !m_f) mq.push_back(wd);
            end
        end

        initial forever begin
            @(negedge clk);
            check($sformatf("s%0d count", SL), int'(cnt), mq.size());
            check($sformatf("s%0d full", SL), int'(full), int'(mq.size() == SL));
            check($sformatf("s%0d empty", SL), int'(empty), int'(mq.size() == 0));
            check($sformatf("s%0d afull", SL), int'(afull), int'(mq.size() >= 3));
            check($sformatf("s%0d aempty", SL), int'(aempty), int'(mq.size() <= 1));
            check($sformatf("s%0d ovf", SL), int'(ovf), int'(m_ovf));
            check($sformatf("s%0d udf", SL), int'(udf), int'(m_udf));
            if (FW == 0 || mq.size() != 0)
                check($sformatf("s%0d rd_data", SL), int'(rdata),
                      (FW != 0) ? int'(mq[0]) : int'(m_rd));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic r, input logic [7:0] d);
        clear = c; wr = w; rd = r; wd = d;
        tick();
        clear = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        logic [4:0] exp_ae;
        logic [4:0] exp_af;
        int         wp;
        exp_ae = 5'b00011;
        exp_af = 5'b11000;
        wp     = 50;

        tick(); tick();
        check("reset empty", int'(g_f[0].empty), 1);
        check("reset aempty", int'(g_f[0].aempty), 1);
        check("reset afull", int'(g_f[0].afull), 0);
        check("reset rd_data fwft0", int'(g_f[1].rdata), 0);
        arst_n = 1'b1;
        tick();

        // T1: fill, overflow, drain in order
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
        check("t1 count", int'(g_f[0].cnt), 5);
        check("t1 full", int'(g_f[0].full), 1);
        drive(1'b0, 1'b1, 1'b0, 8'h99);
        check("t1 ovf", int'(g_f[0].ovf), 1);
        check("t1 count after ovf", int'(g_f[0].cnt), 5);
        for (int i = 0; i < 5; i++) begin
            check("t1 read order", int'(g_f[0].rdata), 8'h11 + i);
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        check("t1 empty", int'(g_f[0].empty), 1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);

        // T2: staggered write/read pairs across pointer wrap
        drive(1'b0, 1'b1, 1'b0, 8'h30);
        drive(1'b0, 1'b1, 1'b0, 8'h31);
        for (int i = 0; i < 10; i++) begin
            check("t2 head", int'(g_f[0].rdata), 8'h30 + i);
            drive(1'b0, 1'b1, 1'b1, 8'(8'h32 + i));
            check("t2 count<=2", int'(g_f[0].cnt <= 2), 1);
        end
        for (int i = 10; i < 12; i++) begin
            check("t2 tail", int'(g_f[0].rdata), 8'h30 + i);
            drive(1'b0, 1'b0, 1'b1, 8'h00);
        end
        check("t2 empty", int'(g_f[0].empty), 1);

        // T3: simultaneous wr+rd when full and when empty
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
        drive(1'b0, 1'b1, 1'b1, 8'hEE);
        check("t3 full count", int'(g_f[0].cnt), 4);
        check("t3 full ovf", int'(g_f[0].ovf), 1);
        check("t3 next head", int'(g_f[0].rdata), 8'h51);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'h77);
        check("t3 empty count", int'(g_f[0].cnt), 1);
        check("t3 empty udf", int'(g_f[0].udf), 1);
        check("t3 written head", int'(g_f[0].rdata), 8'h77);
        drive(1'b1, 1'b0, 1'b0, 8'h00);

        // T4: threshold flags on the 4-slot instance
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t4 aempty c=%0d", c), int'(g_f[1].aempty), int'(exp_ae[c]));
            check($sformatf("t4 afull c=%0d", c), int'(g_f[1].afull), int'(exp_af[c]));
            drive(1'b0, 1'b1, 1'b0, 8'(8'hC0 + c));
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00);

        // T5: registered read latency and hold
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        check("t5 rd_data", int'(g_f[1].rdata), 8'hA5);
        tick(); tick();
        check("t5 rd_data held", int'(g_f[1].rdata), 8'hA5);

        // T6: clear with entries and ovf, then asynchronous reset mid-burst
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        check("t6 pre count", int'(g_f[0].cnt), 3);
        check("t6 pre ovf", int'(g_f[0].ovf), 1);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("t6 clear count", int'(g_f[0].cnt), 0);
        check("t6 clear empty", int'(g_f[0].empty), 1);
        check("t6 clear ovf", int'(g_f[0].ovf), 0);
        wr = 1'b1; wd = 8'h90; tick();
        wd = 8'h91; tick();
        wd = 8'h92;
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("t6 arst count", int'(g_f[0].cnt), 0);
        check("t6 arst empty", int'(g_f[0].empty), 1);
        check("t6 arst aempty", int'(g_f[0].aempty), 1);
        check("t6 arst full", int'(g_f[0].full), 0);
        check("t6 arst rd_data fwft0", int'(g_f[1].rdata), 0);
        wr = 1'b0;
        tick();
        arst_n = 1'b1;
        tick();

        // Randomised traffic with shifting write/read bias
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) wp = $urandom_range(15, 85);
            wr    = ($urandom_range(0, 99) < wp);
            rd    = ($urandom_range(0, 99) < (100 - wp));
            wd    = 8'($urandom);
            clear = ($urandom_range(0, 199) == 0);
            if (i == 1500) begin
                #2 arst_n = 1'b0;
                tick();
                arst_n = 1'b1;
            end
            tick();
        end
        wr = 1'b0; rd = 1'b0; clear = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
